// File: rtl/klp32_hazard_pkg.sv
// rtl/klp32_hazard_pkg.sv - shared types and forwarding-priority helper for the KLP32V2 hazard controller
package klp32_hazard_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      FLUSH      = 2'd3
   } hazard_state_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

   // Memory stage wins over writeback; x0 is hardwired zero and never forwarded.
   function automatic fwd_sel_e fwd_pick(
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] m_rd,
      input logic                  m_wr,
      input logic [REG_ADDR_W-1:0] w_rd,
      input logic                  w_wr
   );
      if (m_wr && m_rd != '0 && m_rd == rs)
         return FWD_MEM;
      else if (w_wr && w_rd != '0 && w_rd == rs)
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   import klp32_hazard_pkg::*;

   logic [REG_ADDR_W-1:0] i_d_rs1, i_d_rs2;
   logic                  i_d_uses_rs1, i_d_uses_rs2;
   logic [REG_ADDR_W-1:0] i_e_rs1, i_e_rs2, i_e_rd;
   logic                  i_e_reg_wr_en, i_e_is_load;
   logic [REG_ADDR_W-1:0] i_m_rd, i_w_rd;
   logic                  i_m_reg_wr_en, i_w_reg_wr_en;
   logic                  i_br_taken, i_mem_req, i_mem_ready;
   logic                  o_pc_en;
   logic                  o_fd_en, o_de_en, o_em_en, o_mw_en;
   logic                  o_fd_flush, o_de_flush, o_em_flush, o_mw_flush;
   logic [1:0]            o_fwd_a_sel, o_fwd_b_sel;
   logic [1:0]            o_state;
   logic [CNT_W-1:0]      o_stall_count;
   logic                  o_mem_timeout;

   modport slave (
      input  i_d_rs1, i_d_rs2, i_d_uses_rs1, i_d_uses_rs2,
      input  i_e_rs1, i_e_rs2, i_e_rd, i_e_reg_wr_en, i_e_is_load,
      input  i_m_rd, i_m_reg_wr_en, i_w_rd, i_w_reg_wr_en,
      input  i_br_taken, i_mem_req, i_mem_ready,
      output o_pc_en, o_fd_en, o_de_en, o_em_en, o_mw_en,
      output o_fd_flush, o_de_flush, o_em_flush, o_mw_flush,
      output o_fwd_a_sel, o_fwd_b_sel, o_state, o_stall_count, o_mem_timeout
   );

   modport master (
      output i_d_rs1, i_d_rs2, i_d_uses_rs1, i_d_uses_rs2,
      output i_e_rs1, i_e_rs2, i_e_rd, i_e_reg_wr_en, i_e_is_load,
      output i_m_rd, i_m_reg_wr_en, i_w_rd, i_w_reg_wr_en,
      output i_br_taken, i_mem_req, i_mem_ready,
      input  o_pc_en, o_fd_en, o_de_en, o_em_en, o_mw_en,
      input  o_fd_flush, o_de_flush, o_em_flush, o_mw_flush,
      input  o_fwd_a_sel, o_fwd_b_sel, o_state, o_stall_count, o_mem_timeout
   );

endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - execute-stage operand forwarding selects for both ALU operands
module hazard_fwd_unit
   import klp32_hazard_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] e_rs1,
   input  logic [REG_ADDR_W-1:0] e_rs2,
   input  logic [REG_ADDR_W-1:0] m_rd,
   input  logic                  m_wr,
   input  logic [REG_ADDR_W-1:0] w_rd,
   input  logic                  w_wr,
   output fwd_sel_e              fwd_a,
   output fwd_sel_e              fwd_b
);

   assign fwd_a = fwd_pick(e_rs1, m_rd, m_wr, w_rd, w_wr);
   assign fwd_b = fwd_pick(e_rs2, m_rd, m_wr, w_rd, w_wr);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, redirect flush and memory-wait sequencing for the KLP32V2 pipeline
module hazard_ctrl
   import klp32_hazard_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int MEM_TIMEOUT       = 64,
   parameter int CNT_W             = 32
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  hz
);

   localparam logic [1:0] LS_INIT = 2'(LOAD_STALL_CYCLES - 1);

   hazard_state_e    state, state_nxt;
   logic [1:0]       ls_cnt, ls_cnt_nxt;
   logic [CNT_W-1:0] stall_count;
   logic             mem_wait, load_use, stalled, tmo;
   logic             pc_en, fd_en, de_en, em_en;
   logic             fd_fl, de_fl, em_fl, mw_fl;
   fwd_sel_e         fwd_a, fwd_b;

   hazard_fwd_unit u_fwd (
      .e_rs1 (hz.i_e_rs1),
      .e_rs2 (hz.i_e_rs2),
      .m_rd  (hz.i_m_rd),
      .m_wr  (hz.i_m_reg_wr_en),
      .w_rd  (hz.i_w_rd),
      .w_wr  (hz.i_w_reg_wr_en),
      .fwd_a (fwd_a),
      .fwd_b (fwd_b)
   );

   always_comb begin
      mem_wait = hz.i_mem_req & ~hz.i_mem_ready;
      load_use = hz.i_e_is_load & hz.i_e_reg_wr_en & (hz.i_e_rd != '0) &
                 ((hz.i_d_uses_rs1 & (hz.i_e_rd == hz.i_d_rs1)) |
                  (hz.i_d_uses_rs2 & (hz.i_e_rd == hz.i_d_rs2)));
   end

   // Detection in RUN only arms the sequence; the bubbles are issued from LOAD_STALL.
   always_comb begin
      state_nxt  = state;
      ls_cnt_nxt = ls_cnt;
      pc_en = 1'b1;
      fd_en = 1'b1;
      de_en = 1'b1;
      em_en = 1'b1;
      fd_fl = 1'b0;
      de_fl = 1'b0;
      em_fl = 1'b0;
      mw_fl = 1'b0;
      if (mem_wait) begin
         pc_en     = 1'b0;
         fd_en     = 1'b0;
         de_en     = 1'b0;
         em_en     = 1'b0;
         mw_fl     = 1'b1;
         state_nxt = MEM_WAIT;
      end else if (hz.i_br_taken) begin
         fd_fl     = 1'b1;
         de_fl     = 1'b1;
         em_fl     = 1'b1;
         state_nxt = FLUSH;
      end else begin
         case (state)
            RUN: begin
               if (load_use) begin
                  state_nxt  = LOAD_STALL;
                  ls_cnt_nxt = LS_INIT;
               end
            end
            LOAD_STALL: begin
               pc_en = 1'b0;
               fd_en = 1'b0;
               de_fl = 1'b1;
               if (ls_cnt == 2'd0)
                  state_nxt = RUN;
               else
                  ls_cnt_nxt = ls_cnt - 2'd1;
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   assign stalled = ~pc_en | fd_fl | de_fl | em_fl | mw_fl;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         ls_cnt      <= 2'd0;
         stall_count <= '0;
      end else begin
         state  <= state_nxt;
         ls_cnt <= ls_cnt_nxt;
         if (stalled && stall_count != '1)
            stall_count <= stall_count + CNT_W'(1);
      end
   end

   generate
      if (MEM_TIMEOUT > 0) begin : g_tmo
         localparam int TW = $clog2(MEM_TIMEOUT + 1);
         logic [TW-1:0] wait_cnt;
         always_ff @(posedge clk) begin
            if (reset) begin
               wait_cnt <= '0;
               tmo      <= 1'b0;
            end else if (state == MEM_WAIT) begin
               if (wait_cnt != TW'(MEM_TIMEOUT))
                  wait_cnt <= wait_cnt + TW'(1);
               if (wait_cnt == TW'(MEM_TIMEOUT - 1))
                  tmo <= 1'b1;
            end else begin
               wait_cnt <= '0;
            end
         end
      end else begin : g_no_tmo
         assign tmo = 1'b0;
      end
   endgenerate

   // Reset forces a transparent pipeline regardless of what the stages present.
   assign hz.o_pc_en       = pc_en | reset;
   assign hz.o_fd_en       = fd_en | reset;
   assign hz.o_de_en       = de_en | reset;
   assign hz.o_em_en       = em_en | reset;
   assign hz.o_mw_en       = 1'b1;
   assign hz.o_fd_flush    = fd_fl & ~reset;
   assign hz.o_de_flush    = de_fl & ~reset;
   assign hz.o_em_flush    = em_fl & ~reset;
   assign hz.o_mw_flush    = mw_fl & ~reset;
   assign hz.o_fwd_a_sel   = reset ? FWD_RF : fwd_a;
   assign hz.o_fwd_b_sel   = reset ? FWD_RF : fwd_b;
   assign hz.o_state       = state;
   assign hz.o_stall_count = stall_count;
   assign hz.o_mem_timeout = tmo;

endmodule
